// File: rtl/alu_seq_pkg.sv
// Shared phase-bus definitions for the sequence counter and its datapath responders.
package alu_seq_pkg;

    localparam int unsigned NUM_PHASES = 6;

    localparam int unsigned PH_INIT  = 0;
    localparam int unsigned PH_TEST  = 1;
    localparam int unsigned PH_ADD   = 2;
    localparam int unsigned PH_SHIFT = 3;
    localparam int unsigned PH_COUNT = 4;
    localparam int unsigned PH_STORE = 5;

    // True when exactly one phase line is active.
    function automatic logic is_onehot6(input logic [NUM_PHASES-1:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/mul_iter_cnt.sv
// Saturating iteration counter for the shift-add loop; flags the increment that completes it.
module mul_iter_cnt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CntMax);

    // Next count: clear wins, then a non-wrapping increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    // Terminal when this increment lands exactly on WIDTH.
    assign term_o = inc_i && !clr_i && !at_max && ((cnt_q + CntOne) == CntMax);

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_phase_responder.sv
// Shift-add multiplier driven one micro-step per phase by the sequence counter's one-hot bus.
module alu_phase_responder
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               fi0,
    input  logic               fi1,
    input  logic               fi2,
    input  logic               fi3,
    input  logic               fi4,
    input  logic               fi5,
    input  logic [WIDTH-1:0]   A_IN,
    input  logic [WIDTH-1:0]   B_IN,
    output logic               END,
    output logic [2*WIDTH-1:0] PROD,
    output logic               VALID,
    output logic               ERR
);

    logic [NUM_PHASES-1:0] ph;
    logic                  ph_idle, ph_onehot, ph_viol, ph_ok;
    logic                  term;

    logic [WIDTH-1:0]      m_q, q_q, acc_q;
    logic                  c_q, q0_q, armed_q;
    logic                  end_q, valid_q, err_q;
    logic [2*WIDTH-1:0]    prod_q;
    logic [WIDTH:0]        sum;

    assign ph        = {fi5, fi4, fi3, fi2, fi1, fi0};
    assign ph_idle   = (ph == '0);
    assign ph_onehot = is_onehot6(ph);

    // fi0 is always accepted; other phases need an armed operation, and END
    // separates the loop phases (END=0) from the store phase (END=1).
    assign ph_viol = !ph_idle &&
                     (!ph_onehot ||
                      (!ph[PH_INIT] && (!armed_q ||
                                        ( ph[PH_STORE] && !end_q) ||
                                        (!ph[PH_STORE] &&  end_q))));
    assign ph_ok   = ph_onehot && !ph_viol;

    assign sum = {1'b0, acc_q} + {1'b0, m_q};

    mul_iter_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (ph_ok && ph[PH_INIT]),
        .inc_i  (ph_ok && ph[PH_COUNT]),
        .term_o (term)
    );

    // Datapath and registered outputs; a violation only sets the sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            q0_q    <= 1'b0;
            armed_q <= 1'b0;
            end_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            prod_q  <= '0;
        end else if (ph_viol) begin
            err_q <= 1'b1;
        end else if (ph_ok) begin
            unique case (1'b1)
                ph[PH_INIT]: begin
                    m_q     <= A_IN;
                    q_q     <= B_IN;
                    acc_q   <= '0;
                    c_q     <= 1'b0;
                    q0_q    <= 1'b0;
                    end_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    armed_q <= 1'b1;
                end
                ph[PH_TEST]: q0_q <= q_q[0];
                ph[PH_ADD]: begin
                    if (q0_q) begin
                        {c_q, acc_q} <= sum;
                    end
                end
                ph[PH_SHIFT]: begin
                    // {C,ACC,Q} >> 1; carry is consumed here.
                    acc_q <= {c_q, acc_q[WIDTH-1:1]};
                    q_q   <= {acc_q[0], q_q[WIDTH-1:1]};
                    c_q   <= 1'b0;
                end
                ph[PH_COUNT]: begin
                    if (term) begin
                        end_q <= 1'b1;
                    end
                end
                ph[PH_STORE]: begin
                    prod_q  <= {acc_q, q_q};
                    valid_q <= 1'b1;
                    armed_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign END   = end_q;
    assign PROD  = prod_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: doc/alu_phase_responder.md
Name: alu_phase_responder

Overview:
- Datapath responder on the far side of the sequence counter's one-hot phase bus (fi0..fi5) and BGN/END handshake.
- Executes an unsigned radix-2 shift-add multiply, one micro-step per active phase.
- Returns END to the sequence counter when the iteration count is exhausted, which steers the counter from the loop into fi5.
- Flags protocol violations on the phase bus.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- fi0  in  1  phase 0: init/load.
- fi1  in  1  phase 1: test multiplier LSB.
- fi2  in  1  phase 2: conditional add.
- fi3  in  1  phase 3: shift right.
- fi4  in  1  phase 4: count and check.
- fi5  in  1  phase 5: store result.
- A_IN  in  WIDTH  multiplicand, sampled in fi0.
- B_IN  in  WIDTH  multiplier, sampled in fi0.
- END  out  1  registered; tells the counter the loop is finished.
- PROD  out  2*WIDTH  registered product.
- VALID  out  1  registered; PROD holds a fresh result.
- ERR  out  1  registered, sticky phase-protocol error.

Behaviour:
- Reset (RST=1 at a CLK edge) clears everything: END=0, PROD=0, VALID=0, ERR=0; internal M, Q, ACC, cnt all 0; armed=0. Reset wins over any simultaneous phase.
- The phase vector {fi5..fi0} is sampled every rising edge.
- Legal vectors are all-zero (hold, no state change) or exactly one bit set.
- fi0 (always legal):
  - M<=A_IN, Q<=B_IN, ACC<=0, cnt<=0.
  - END<=0, VALID<=0, ERR<=0, armed<=1.
  - Re-entry of fi0 mid-operation restarts cleanly.
- fi1: latch bit q0<=Q[0].
- fi2: if q0, ACC<=ACC+M with carry kept in the extra bit C (WIDTH+1-bit sum).
- fi3: {C,ACC,Q} <= {C,ACC,Q} >> 1, then C<=0.
- fi4:
  - cnt<=cnt+1.
  - If cnt+1==WIDTH, END<=1 (visible the cycle after this fi4).
  - cnt saturates at WIDTH; further fi4 does not wrap.
- fi5 with END=1:
  - PROD<={ACC,Q}, VALID<=1, armed<=0.
  - END stays 1 until the next fi0 or RST.
- Violations:
  - ERR<=1 on a multi-hot vector.
  - ERR<=1 on any of fi1..fi5 while armed=0.
  - ERR<=1 on fi5 while END=0.
  - ERR<=1 on fi1..fi4 while END=1.
  - On any violation, datapath and outputs other than ERR are unchanged.
  - ERR is sticky until fi0 or RST.
- Latency:
  - A fully compliant run is 1 fi0 + 4*WIDTH loop phases + 1 fi5.
  - VALID rises one cycle after the fi5 edge.
  - With no idle cycles between phases, VALID rises 4*WIDTH+2 active phase cycles after fi0.
- Idle (all-zero) cycles may be interleaved anywhere without affecting the result.

Decomposition:
- Shared package alu_seq_pkg:
  - Phase index constants PH_INIT=0, PH_TEST=1, PH_ADD=2, PH_SHIFT=3, PH_COUNT=4, PH_STORE=5.
  - localparam NUM_PHASES=6.
  - One-hot checker function is_onehot6.
- The sequence counter imports the same package.
- One natural sub-module, mul_iter_cnt:
  - Saturating CNT_W counter with clear (fi0), increment (fi4) and a terminal flag used to set END.

Test Plan:
- Reset; fi0 with A_IN=3, B_IN=5; 8 compliant fi1..fi4 loops -> END rises after the 8th fi4; fi5 -> PROD=15, VALID=1, ERR=0.
- A_IN=255, B_IN=255, compliant run with random idle cycles between phases -> PROD=65025, END only after the 8th fi4.
- A_IN=0, B_IN=200 -> PROD=0, VALID=1; then fi0 -> VALID=0, END=0.
- After fi0, drive fi1 and fi2 together -> ERR=1 next cycle, ACC/Q/cnt unchanged; ERR holds through later phases until next fi0 clears it.
- fi5 after only 3 loops (END=0) -> ERR=1, VALID stays 0, PROD keeps its previous value.
- RST=1 asserted during 4th-iteration fi2 -> next cycle END=0, PROD=0, VALID=0, ERR=0; following fi1 without fi0 -> ERR=1.
